// File: rtl/serial_word_deser.sv
// Bit-serial to parallel word deserializer with valid/ready on both sides.
// Optional alternating-pattern checker on pattern_ok, enabled by SERIAL_WORD_PATTERN_CHECK_EN.
module serial_word_deser #(
    parameter int unsigned BYTES         = 4,
    parameter int unsigned BITS_PER_BYTE = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_bit,
    input  logic                     in_flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [0:BYTES*BITS_PER_BYTE-1] out_word,
    output logic [0:BYTES*BITS_PER_BYTE-1] out_inv,
    output logic [((BYTES > 1) ? $clog2(BYTES) : 1)-1:0] byte_idx,
    output logic [((BITS_PER_BYTE > 1) ? $clog2(BITS_PER_BYTE) : 1)-1:0] bit_idx,
    output logic [15:0]              word_cnt,
    output logic                     pattern_ok
);

    localparam int unsigned WIDTH = BYTES * BITS_PER_BYTE;
    localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned KW    = (BITS_PER_BYTE > 1) ? $clog2(BITS_PER_BYTE) : 1;
    localparam int unsigned IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [BW-1:0]      j_q;
    logic [KW-1:0]      k_q;
    logic [0:WIDTH-1]   shreg;
    logic [0:WIDTH-1]   shreg_nxt_c;
    logic [IW-1:0]      idx_c;
    logic               accept_c;
    logic               flush_c;
    logic               handoff_c;
    logic               last_c;
    logic               k_wrap_c;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= COLLECT;
        else        state_q <= state_d;
    end

    // Next state: a word completing during a handoff keeps the block in FULL
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (last_c)    state_d = FULL;
            FULL:    if (handoff_c) state_d = last_c ? FULL : COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Handshake and control decode
    always_comb begin
        in_ready  = 1'b0;
        handoff_c = 1'b0;
        flush_c   = 1'b0;
        if (rst_n) begin
            in_ready  = (state_q == COLLECT) || out_ready;
            handoff_c = (state_q == FULL) && out_ready;
            flush_c   = (state_q == COLLECT) && in_flush;
        end
        accept_c = in_valid && in_ready && !flush_c;
        k_wrap_c = (k_q == KW'(BITS_PER_BYTE - 1));
        last_c   = accept_c && k_wrap_c && (j_q == BW'(BYTES - 1));
    end

    // Shift register image including the bit being accepted this cycle
    always_comb begin
        idx_c       = IW'(j_q) * IW'(BITS_PER_BYTE) + IW'(k_q);
        shreg_nxt_c = shreg;
        shreg_nxt_c[idx_c] = in_bit;
    end

    // Datapath: counters, collected bits, output word and handoff count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            j_q       <= '0;
            k_q       <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
            word_cnt  <= '0;
        end else begin
            if (handoff_c) begin
                out_valid <= 1'b0;
                word_cnt  <= word_cnt + 16'd1;
            end
            if (flush_c) begin
                j_q <= '0;
                k_q <= '0;
            end else if (accept_c) begin
                shreg[idx_c] <= in_bit;
                if (last_c) begin
                    j_q       <= '0;
                    k_q       <= '0;
                    out_word  <= shreg_nxt_c;
                    out_valid <= 1'b1;
                end else if (k_wrap_c) begin
                    k_q <= '0;
                    j_q <= j_q + BW'(1);
                end else begin
                    k_q <= k_q + KW'(1);
                end
            end
        end
    end

    assign byte_idx = j_q;
    assign bit_idx  = k_q;
    assign out_inv  = ~out_word;

`ifdef SERIAL_WORD_PATTERN_CHECK_EN
    logic [0:WIDTH-1] alt_c;

    // Reference pattern: word index n carries n&1
    always_comb begin
        for (int n = 0; n < WIDTH; n++) begin
            alt_c[n] = n[0];
        end
        pattern_ok = out_valid && (out_word == alt_c);
    end
`else
    assign pattern_ok = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_deser.sv
// Directed bench for serial_word_deser: table-driven counter checks plus
// hand-written backpressure, flush, reset and gapped-input sequences.
module tb_serial_word_deser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_bit;
    logic        in_flush;
    logic        out_valid;
    logic        out_ready;
    logic [0:31] out_word;
    logic [0:31] out_inv;
    logic [1:0]  byte_idx;
    logic [2:0]  bit_idx;
    logic [15:0] word_cnt;
    logic        pattern_ok;

    int total = 0;
    int bad   = 0;
    int nbit  = 0;

    typedef struct {
        int         count;
        logic [1:0] exp_byte;
        logic [2:0] exp_bit;
        logic       exp_valid;
    } vec_t;

    vec_t vecs [6];

`ifdef SERIAL_WORD_PATTERN_CHECK_EN
    localparam logic EXP_PAT = 1'b1;
`else
    localparam logic EXP_PAT = 1'b0;
`endif

    serial_word_deser dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bit     (in_bit),
        .in_flush   (in_flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_inv    (out_inv),
        .byte_idx   (byte_idx),
        .bit_idx    (bit_idx),
        .word_cnt   (word_cnt),
        .pattern_ok (pattern_ok)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Present one bit for one cycle; back-to-back calls give a continuous stream
    task automatic send_bit(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_alt(input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(1'(nbit & 1));
            nbit++;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_flush = 1'b0; out_ready = 1'b1;
        vecs[0] = '{1,  2'd0, 3'd1, 1'b0};
        vecs[1] = '{8,  2'd1, 3'd0, 1'b0};
        vecs[2] = '{19, 2'd2, 3'd3, 1'b0};
        vecs[3] = '{24, 2'd3, 3'd0, 1'b0};
        vecs[4] = '{31, 2'd3, 3'd7, 1'b0};
        vecs[5] = '{32, 2'd0, 3'd0, 1'b1};

        // Reset state
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word", out_word, 32'h0);
        chk("rst_out_inv", out_inv, 32'hFFFFFFFF);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_pattern_ok", 32'(pattern_ok), 32'd0);
        chk("rst_idx", {byte_idx, bit_idx}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Alternating stream, continuous, counters checked from the table
        nbit = 0;
        for (int v = 0; v < 6; v++) begin
            send_alt(vecs[v].count - nbit);
            chk($sformatf("tbl%0d_byte", v), 32'(byte_idx), 32'(vecs[v].exp_byte));
            chk($sformatf("tbl%0d_bit", v), 32'(bit_idx), 32'(vecs[v].exp_bit));
            chk($sformatf("tbl%0d_valid", v), 32'(out_valid), 32'(vecs[v].exp_valid));
        end
        chk("alt_word", out_word, 32'h55555555);
        chk("alt_inv", out_inv, 32'hAAAAAAAA);
        chk("alt_pattern_ok", 32'(pattern_ok), 32'(EXP_PAT));
        tick();
        chk("alt_valid_drop", 32'(out_valid), 32'd0);
        chk("alt_word_cnt", 32'(word_cnt), 32'd1);

        // Backpressure with an all-ones word; a flush while FULL is ignored
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) send_bit(1'b1);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_word", out_word, 32'hFFFFFFFF);
        chk("bp_pattern_ok", 32'(pattern_ok), 32'd0);
        in_valid = 1'b1;
        in_bit   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_flush = (c == 4);
            #1;
            chk($sformatf("bp_in_ready_%0d", c), 32'(in_ready), 32'd0);
            tick();
            chk($sformatf("bp_hold_word_%0d", c), out_word, 32'hFFFFFFFF);
            chk($sformatf("bp_hold_valid_%0d", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold_idx_%0d", c), {byte_idx, bit_idx}, 32'd0);
        end
        in_flush  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_bit_idx", 32'(bit_idx), 32'd1);
        chk("bp_byte_idx", 32'(byte_idx), 32'd0);
        chk("bp_word_cnt", 32'(word_cnt), 32'd2);
        chk("bp_valid_drop", 32'(out_valid), 32'd0);

        // Flush: clear the leftover bit, take 13 ones, flush with a valid bit
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        chk("fl_clear_idx", {byte_idx, bit_idx}, 32'd0);
        for (int i = 0; i < 13; i++) send_bit(1'b1);
        chk("fl_13_byte", 32'(byte_idx), 32'd1);
        chk("fl_13_bit", 32'(bit_idx), 32'd5);
        in_flush = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        #1;
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_idx", {byte_idx, bit_idx}, 32'd0);
        nbit = 0;
        send_alt(32);
        chk("fl_word", out_word, 32'h55555555);
        chk("fl_valid", 32'(out_valid), 32'd1);
        tick();
        chk("fl_word_cnt", 32'(word_cnt), 32'd3);

        // Reset mid-word
        nbit = 0;
        send_alt(20);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_idx", {byte_idx, bit_idx}, 32'd0);
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_word_cnt", 32'(word_cnt), 32'd0);
        nbit = 0;
        send_alt(32);
        chk("mr_word", out_word, 32'h55555555);
        chk("mr_valid_after", 32'(out_valid), 32'd1);
        tick();
        chk("mr_word_cnt_after", 32'(word_cnt), 32'd1);

        // Gapped input: one bit every third cycle
        nbit = 0;
        for (int i = 0; i < 32; i++) begin
            send_alt(1);
            if (i == 18) begin
                chk("gap_byte", 32'(byte_idx), 32'd2);
                chk("gap_bit", 32'(bit_idx), 32'd3);
            end
            if (i != 31) begin
                tick();
                tick();
            end
        end
        chk("gap_valid", 32'(out_valid), 32'd1);
        chk("gap_word", out_word, 32'h55555555);
        chk("gap_pattern_ok", 32'(pattern_ok), 32'(EXP_PAT));
        tick();
        chk("gap_word_cnt", 32'(word_cnt), 32'd2);
        chk("gap_valid_drop", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_word_deser.md
Name: serial_word_deser

Overview:
- Receive-side counterpart of the bit-serial word producers used in the basic test suite.
- Accepts a stream of single bits through a valid/ready handshake and packs them into a BYTES x BITS_PER_BYTE word.
- Packing uses nested byte/bit counters. Bit n of the stream lands in word index n, with ascending [0:WIDTH-1] indexing.
- Presents each completed word on a valid/ready output port, with an inverted copy and a word counter.

Parameters:
- BYTES, 4, number of bytes per word.
- BITS_PER_BYTE, 8, bits per byte.
- WIDTH (localparam), BYTES*BITS_PER_BYTE, word width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  in_bit is valid this cycle.
- in_ready  output  1  block accepts a bit this cycle.
- in_bit  input  1  serial data bit.
- in_flush  input  1  discard any partially collected word.
- out_valid  output  1  out_word holds a complete word.
- out_ready  input  1  consumer takes the word this cycle.
- out_word  output  [0:WIDTH-1]  assembled word; index 0 is the first bit received.
- out_inv  output  [0:WIDTH-1]  bitwise inverse of out_word.
- byte_idx  output  max(1,$clog2(BYTES))  current byte counter j.
- bit_idx  output  max(1,$clog2(BITS_PER_BYTE))  current bit counter k.
- word_cnt  output  16  completed words handed off; wraps at 2^16.
- pattern_ok  output  1  see Optional Feature.

Behaviour:
- Reset: synchronous, sampled on the rising edge of clk while rst_n=0. All of the following take effect:
  - state=COLLECT; j=k=0.
  - out_valid=0, out_word=0, word_cnt=0.
  - in_ready is forced to 0 while rst_n=0.
  - out_inv and pattern_ok are combinational from out_word; after reset they read all-ones and 0 respectively.
- States:
  - COLLECT: in_ready=1.
  - FULL: in_ready=out_ready.
- Accept condition: a bit is accepted when in_valid && in_ready. On accept:
  - Write the bit to shreg[j*BITS_PER_BYTE+k].
  - If k==BITS_PER_BYTE-1, set k=0 and increment j; otherwise increment k.
- Word completion: on accepting the bit at j==BYTES-1 and k==BITS_PER_BYTE-1:
  - Load out_word from shreg, including the bit just accepted.
  - Set out_valid=1, reset j and k to 0, go to FULL.
  - Latency: last bit accepted at edge t, out_valid=1 from edge t (visible in cycle t+1).
- FULL with out_ready=0: out_word, out_valid and the counters are held stable; no bits are accepted.
- FULL with out_ready=1: the word is handed off.
  - out_valid drops to 0 at the next edge and word_cnt increments (wraps from 0xFFFF to 0).
  - State returns to COLLECT.
  - A bit presented in the same cycle is accepted as bit 0 of the next word.
- Continuous streaming: a single-bit word (BYTES=BITS_PER_BYTE=1) never sets FULL back-to-back on its own. Completion in the same cycle as a handoff is permitted only through the handoff path above.
- in_flush in COLLECT:
  - Sets j=k=0. Partial shreg contents are don't-care, because they will be overwritten.
  - Has priority over a simultaneous in_valid: that bit is dropped, but in_ready still reads 1.
- in_flush in FULL: ignored; the held word is unaffected.
- Gaps in in_valid: counters are held.
- Reset mid-word or mid-FULL: the partial or held word is lost, word_cnt is cleared, and no out_valid pulse is produced.

Optional Feature:
- Macro: SERIAL_WORD_PATTERN_CHECK_EN.
- Defined: pattern_ok=1 iff out_valid=1 and out_word[n]==(n&1) for every n (alternating check pattern); otherwise 0. This is combinational, from registered out_word and out_valid.
- Undefined: pattern_ok is tied to 1'b0 and no comparator logic exists. The port remains present in both builds.

Test Plan:
- Alternating stream: reset, then 32 bits with in_bit=n&1, in_valid=1 every cycle, out_ready=1.
  - out_valid is high exactly one cycle after the 32nd bit.
  - out_word=32'h55555555, out_inv=32'hAAAAAAAA, word_cnt=1.
  - pattern_ok=1 if the macro is defined, else 0.
- Backpressure: complete a word of all ones with out_ready=0 and hold 10 cycles.
  - in_ready=0 and out_word=32'hFFFFFFFF stay stable throughout.
  - Then out_ready=1 with in_valid=1, in_bit=0: that bit is accepted; next cycle bit_idx=1, byte_idx=0, word_cnt increments.
- Counters: after 19 accepted bits, byte_idx=2 and bit_idx=3; after 24 bits, byte_idx=3 and bit_idx=0.
- Flush:
  - Accept 13 ones, assert in_flush together with in_valid, then send 32 bits of the alternating pattern: out_word=32'h55555555.
  - in_flush during FULL leaves out_word unchanged.
- Reset mid-word: rst_n=0 for one cycle after bit 20.
  - Counters read 0, out_valid=0, word_cnt=0.
  - A following full 32-bit word completes normally.
- Gapped input: in_valid high every third cycle for the alternating pattern gives the same out_word=32'h55555555, with word_cnt increments matching the handoffs.
